// File: rtl/cordic_arbiter.sv
// Round-robin front end that lets NCH channels share one pipelined CORDIC.
// Results come back LATENCY+2 cycles after acceptance. They are tagged with the channel index and appear in acceptance order.
module cordic_arbiter #(
  parameter int WIDTH   = 16,
  parameter int ZWIDTH  = 24,
  parameter int NCH     = 4,
  parameter int CW      = 2,
  parameter int LATENCY = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  input  logic [NCH*WIDTH-1:0]  in_x,
  input  logic [NCH*WIDTH-1:0]  in_y,
  input  logic [NCH*ZWIDTH-1:0] in_z,
  output logic [WIDTH-1:0]      c_xi,
  output logic [WIDTH-1:0]      c_yi,
  output logic [ZWIDTH-1:0]     c_zi,
  output logic                  c_stb_in,
  input  logic [WIDTH-1:0]      c_xo,
  input  logic [WIDTH-1:0]      c_yo,
  input  logic [ZWIDTH-1:0]     c_zo,
  input  logic                  c_stb_out,
  output logic                  out_valid,
  output logic [CW-1:0]         out_chan,
  output logic [WIDTH-1:0]      out_x,
  output logic [WIDTH-1:0]      out_y,
  output logic [ZWIDTH-1:0]     out_z,
  output logic [CW+5:0]         inflight,
  output logic                  sync_err
);

  logic [CW-1:0]      last;
  logic [CW-1:0]      gidx;
  logic               gfound;
  logic               accept;
  logic [LATENCY-1:0] tag_vld;
  logic [CW-1:0]      tag_chan [LATENCY];
  logic               head_vld;

  // Search begins just after the last granted channel and wraps around.
  always_comb begin
    gidx   = '0;
    gfound = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      int c;
      c = (int'(last) + k) % NCH;
      if (!gfound && in_valid[c]) begin
        gfound = 1'b1;
        gidx   = CW'(c);
      end
    end
  end

  assign accept = gfound & ~rst;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[gidx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= CW'(NCH - 1);
      c_stb_in <= 1'b0;
      c_xi     <= '0;
      c_yi     <= '0;
      c_zi     <= '0;
    end else begin
      c_stb_in <= accept;
      if (accept) begin
        last <= gidx;
        c_xi <= in_x[int'(gidx)*WIDTH +: WIDTH];
        c_yi <= in_y[int'(gidx)*WIDTH +: WIDTH];
        c_zi <= in_z[int'(gidx)*ZWIDTH +: ZWIDTH];
      end
    end
  end

  // The tag enters with c_stb_in. `last` still holds the granted channel during that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= c_stb_in;
      for (int i = 1; i < LATENCY; i++) tag_vld[i] <= tag_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_chan[0] <= last;
    for (int i = 1; i < LATENCY; i++) tag_chan[i] <= tag_chan[i-1];
  end

  assign head_vld = tag_vld[LATENCY-1];

  // The tag is authoritative for out_valid. A missing or extra core strobe only raises sync_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
      sync_err  <= 1'b0;
      inflight  <= '0;
    end else begin
      out_valid <= head_vld;
      if (head_vld) begin
        out_chan <= tag_chan[LATENCY-1];
        out_x    <= c_xo;
        out_y    <= c_yo;
        out_z    <= c_zo;
      end
      if (head_vld != c_stb_out) sync_err <= 1'b1;
      inflight <= inflight + (CW+6)'(accept) - (CW+6)'(out_valid);
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Randomized bench for cordic_arbiter around a behavioural pipelined CORDIC model.
// A scoreboard predicts grants, results, inflight and sync_err directly from the arbitration rules.
module tb_cordic_arbiter;
  localparam int WIDTH = 16, ZWIDTH = 24, NCH = 4, CW = 2, LATENCY = 16;

  typedef struct packed {
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  y;
    logic [ZWIDTH-1:0] z;
  } res_t;

  typedef struct {
    int   chan;
    res_t r;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drop = 1'b0;
  logic fixed_vec = 1'b0;
  logic [NCH-1:0]        in_valid = '0;
  logic [NCH-1:0]        in_ready;
  logic [NCH*WIDTH-1:0]  in_x = '0, in_y = '0;
  logic [NCH*ZWIDTH-1:0] in_z = '0;
  logic [WIDTH-1:0]      c_xi, c_yi, c_xo, c_yo, out_x, out_y;
  logic [ZWIDTH-1:0]     c_zi, c_zo, out_z;
  logic                  c_stb_in, c_stb_out, out_valid, sync_err;
  logic [CW-1:0]         out_chan;
  logic [CW+5:0]         inflight;

  int checks = 0, failures = 0, cyc = 0;
  int atan_tab [LATENCY];

  always #5 clk = ~clk;

  cordic_arbiter #(.WIDTH(WIDTH), .ZWIDTH(ZWIDTH), .NCH(NCH), .CW(CW), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .c_xi(c_xi), .c_yi(c_yi), .c_zi(c_zi), .c_stb_in(c_stb_in),
    .c_xo(c_xo), .c_yo(c_yo), .c_zo(c_zo), .c_stb_out(c_stb_out),
    .out_valid(out_valid), .out_chan(out_chan), .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .inflight(inflight), .sync_err(sync_err)
  );

  // Rotation-mode CORDIC with one iteration per pipeline stage and no gain correction.
  function automatic res_t golden(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic [ZWIDTH-1:0] z);
    int xi, yi, zi, xn;
    res_t r;
    xi = int'($signed(x));
    yi = int'($signed(y));
    zi = int'($signed(z));
    for (int i = 0; i < LATENCY; i++) begin
      if (zi >= 0) begin
        xn = xi - (yi >>> i); yi = yi + (xi >>> i); zi = zi - atan_tab[i];
      end else begin
        xn = xi + (yi >>> i); yi = yi - (xi >>> i); zi = zi + atan_tab[i];
      end
      xi = xn;
    end
    r.x = xi[WIDTH-1:0];
    r.y = yi[WIDTH-1:0];
    r.z = zi[ZWIDTH-1:0];
    return r;
  endfunction

  // Stand-in for the shared CORDIC core: a LATENCY-stage pipeline that is cleared by rst.
  res_t pr [LATENCY];
  logic [LATENCY-1:0] ps;
  always @(posedge clk) begin
    if (rst) ps <= '0;
    else begin
      ps[0] <= c_stb_in;
      for (int i = 1; i < LATENCY; i++) ps[i] <= ps[i-1];
    end
    pr[0] <= golden(c_xi, c_yi, c_zi);
    for (int i = 1; i < LATENCY; i++) pr[i] <= pr[i-1];
  end
  assign c_stb_out = ps[LATENCY-1] & ~drop;
  assign c_xo = pr[LATENCY-1].x;
  assign c_yo = pr[LATENCY-1].y;
  assign c_zo = pr[LATENCY-1].z;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Scoreboard state
  exp_t q[$];
  int   mptr = NCH - 1, m_infl = 0, m_och = 0;
  logic m_stb = 0, m_sync = 0;
  logic [WIDTH-1:0]  m_cx = '0, m_cy = '0, m_ox = '0, m_oy = '0;
  logic [ZWIDTH-1:0] m_cz = '0, m_oz = '0;

  always @(negedge clk) begin
    int g;
    logic ov;
    logic [NCH-1:0] er;
    exp_t e;
    cyc++;
    if (rst) begin
      check_eq("in_ready_rst", 64'(in_ready), 64'd0);
      q.delete();
      mptr = NCH - 1; m_infl = 0; m_stb = 0; m_sync = 0; m_och = 0;
      m_cx = '0; m_cy = '0; m_cz = '0; m_ox = '0; m_oy = '0; m_oz = '0;
    end else begin
      g = -1;
      for (int k = 1; k <= NCH; k++)
        if (g < 0 && in_valid[(mptr + k) % NCH]) g = (mptr + k) % NCH;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      check_eq("in_ready", 64'(in_ready), 64'(er));
      check_eq("c_stb_in", 64'(c_stb_in), 64'(m_stb));
      check_eq("c_xi", 64'(c_xi), 64'(m_cx));
      check_eq("c_yi", 64'(c_yi), 64'(m_cy));
      check_eq("c_zi", 64'(c_zi), 64'(m_cz));
      check_eq("inflight", 64'(inflight), 64'(m_infl));
      check_eq("sync_err", 64'(sync_err), 64'(m_sync));
      ov = (q.size() > 0) && (q[0].due == cyc);
      check_eq("out_valid", 64'(out_valid), 64'(ov));
      if (ov) begin
        e = q.pop_front();
        m_och = e.chan; m_ox = e.r.x; m_oy = e.r.y; m_oz = e.r.z;
      end
      check_eq("out_chan", 64'(out_chan), 64'(m_och));
      check_eq("out_x", 64'(out_x), 64'(m_ox));
      check_eq("out_y", 64'(out_y), 64'(m_oy));
      check_eq("out_z", 64'(out_z), 64'(m_oz));
      if (drop && q.size() > 0 && q[0].due == cyc + 1) m_sync = 1'b1;
      m_infl = m_infl + ((g >= 0) ? 1 : 0) - (ov ? 1 : 0);
      m_stb = (g >= 0);
      if (g >= 0) begin
        m_cx = in_x[g*WIDTH +: WIDTH];
        m_cy = in_y[g*WIDTH +: WIDTH];
        m_cz = in_z[g*ZWIDTH +: ZWIDTH];
        e.chan = g;
        e.r = golden(m_cx, m_cy, m_cz);
        e.due = cyc + LATENCY + 2;
        q.push_back(e);
        mptr = g;
      end
    end
  end

  task automatic step(input logic [NCH-1:0] v, input logic r, input logic d);
    @(posedge clk);
    #1;
    rst = r;
    drop = d;
    in_valid = v;
    for (int c = 0; c < NCH; c++) begin
      if (fixed_vec) begin
        in_x[c*WIDTH +: WIDTH] = 16'h7FFF;
        in_y[c*WIDTH +: WIDTH] = 16'h0000;
        in_z[c*ZWIDTH +: ZWIDTH] = 24'h100000;
      end else begin
        in_x[c*WIDTH +: WIDTH] = WIDTH'($urandom);
        in_y[c*WIDTH +: WIDTH] = WIDTH'($urandom);
        in_z[c*ZWIDTH +: ZWIDTH] = ZWIDTH'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < LATENCY; i++)
      atan_tab[i] = $rtoi($atan(2.0 ** (-i)) / (2.0 * 3.14159265358979) * (2.0 ** ZWIDTH));
    repeat (3) step('0, 1'b1, 1'b0);
    idle(2);
    // Single request on channel 2
    fixed_vec = 1'b1;
    step(4'b0100, 1'b0, 1'b0);
    fixed_vec = 1'b0;
    idle(25);
    // All channels valid: expect strict rotation
    repeat (12) step(4'b1111, 1'b0, 1'b0);
    idle(20);
    // Channels 1 and 3 valid, then channel 1 drops out
    repeat (4) step(4'b1010, 1'b0, 1'b0);
    repeat (8) step(4'b1000, 1'b0, 1'b0);
    idle(20);
    // Reset with requests still in flight
    repeat (5) step(4'b1111, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    repeat (4) step(4'b1111, 1'b0, 1'b0);
    idle(20);
    // Suppress the core strobe on the expected return cycle
    step(4'b0010, 1'b0, 1'b0);
    idle(LATENCY);
    step('0, 1'b0, 1'b1);
    idle(10);
    step('0, 1'b1, 1'b0);
    idle(5);
    // Fixed vectors interleaved on channels 0 and 1
    fixed_vec = 1'b1;
    repeat (8) step(4'b0011, 1'b0, 1'b0);
    fixed_vec = 1'b0;
    idle(20);
    // Random traffic with occasional resets and dropped strobes
    repeat (1500)
      step(NCH'($urandom), ($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0));
    idle(LATENCY + 6);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
